// File: rtl/count6_pkg.sv
// Shared types and helpers for the count6_ctr counter slice.
// Optional terminal-count output is enabled by defining COUNT6_TC_EN.
package count6_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef logic [DEFAULT_WIDTH-1:0] cnt_t;

    // Which source feeds the count register on the next edge, highest priority first.
    typedef enum logic [1:0] {
        SEL_RST  = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_INC  = 2'd2
    } next_sel_e;

    // All-ones pattern of the given width, returned in a 32-bit container.
    function automatic logic [31:0] all_ones(input int unsigned width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/count6_next.sv
// Combinational next-state selection for count6_ctr: reset, then load, then increment.
// Purely combinational; the register lives in the top level.
module count6_next
    import count6_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic [WIDTH-1:0] cnt_o
);

    next_sel_e sel;

    always_comb begin
        sel = SEL_INC;
        if (rst_i) begin
            sel = SEL_RST;
        end else if (load_i) begin
            sel = SEL_LOAD;
        end
    end

    always_comb begin
        // NOTE: assign a default before the case so every path drives cnt_o and no latch is inferred.
        cnt_o = cnt_i + WIDTH'(1);
        case (sel)
            SEL_RST:  cnt_o = '0;
            SEL_LOAD: cnt_o = data_i;
            SEL_INC:  cnt_o = cnt_i + WIDTH'(1);
            default:  cnt_o = cnt_i + WIDTH'(1);
        endcase
    end

endmodule

// File: rtl/count6_ctr.sv
// WIDTH-bit free-running up-counter with synchronous parallel load.
// Define COUNT6_TC_EN to add the registered terminal-count output tc.
module count6_ctr
    import count6_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
`ifdef COUNT6_TC_EN
    output logic             tc,
`endif
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    count6_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .rst_i  (rst),
        .load_i (load),
        .data_i (data),
        .cnt_i  (cnt_q),
        .cnt_o  (cnt_d)
    );

    // Reset is also applied directly at the flop so synthesis sees an explicit sync reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples values from before the edge.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out = cnt_q;

`ifdef COUNT6_TC_EN
    localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

    logic tc_q;
    logic tc_d;

    // Decoded from the next count so the flag lines up with out, including loads of all-ones.
    assign tc_d = (cnt_d == ONES);

    always_ff @(posedge clk) begin
        if (rst) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= tc_d;
        end
    end

    assign tc = tc_q;
`endif

endmodule

// File: tb/tb_count6_ctr.sv
// Scoreboard bench for count6_ctr: a driver pushes expected values from an arithmetic
// model, and a monitor pops and compares after every rising edge.
module tb_count6_ctr;
    import count6_pkg::*;

    localparam int     W   = DEFAULT_WIDTH;
    localparam longint MOD = 64'd1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] data;
    logic [W-1:0] out;
`ifdef COUNT6_TC_EN
    logic         tc;
`endif

    count6_ctr #(
        .WIDTH (W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .data (data),
`ifdef COUNT6_TC_EN
        .tc   (tc),
`endif
        .out  (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] cnt;
        logic         tc;
        int           idx;
    } exp_t;

    exp_t   exp_q[$];
    int     passed = 0;
    int     total  = 0;
    longint model  = 0;
    int     step_no = 0;
    bit     done   = 1'b0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, req);
        end
    endtask

    // Apply one cycle of stimulus and record what out must read after the next edge.
    task automatic step(input logic r, input logic l, input logic [W-1:0] d);
        exp_t e;
        @(negedge clk);
        rst  = r;
        load = l;
        data = d;
        if (r) begin
            model = 0;
        end else if (l) begin
            model = longint'(d);
        end else begin
            model = (model + 1) % MOD;
        end
        e.cnt = W'(model);
        e.tc  = (model == MOD - 1);
        e.idx = step_no;
        step_no++;
        exp_q.push_back(e);
    endtask

    // Monitor: one output per edge, compared against the oldest pending expectation.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out", e.idx, 32'(out), 32'(e.cnt));
`ifdef COUNT6_TC_EN
                check("tc", e.idx, 32'(tc), 32'(e.tc));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        data = '0;

        // Reset held two edges, then count 1, 2, 3.
        step(1'b1, 1'b0, W'(0));
        step(1'b1, 1'b0, W'(0));
        repeat (3) step(1'b0, 1'b0, W'(0));

        // Single-cycle load of 11, then count on.
        step(1'b0, 1'b1, W'(11));
        repeat (3) step(1'b0, 1'b0, W'($urandom));

        // Wrap through all-ones.
        step(1'b0, 1'b1, W'(62));
        repeat (3) step(1'b0, 1'b0, W'(0));

        // Reset beats load; load takes effect once reset drops.
        step(1'b1, 1'b1, W'(40));
        step(1'b0, 1'b1, W'(40));

        // Load held high while data changes, then released.
        step(1'b0, 1'b1, W'(5));
        step(1'b0, 1'b1, W'(9));
        step(1'b0, 1'b1, W'(17));
        repeat (2) step(1'b0, 1'b0, W'(0));

        // Reset, then a long free run across a wrap.
        step(1'b1, 1'b0, W'(0));
        repeat (80) step(1'b0, 1'b0, W'($urandom));

        // Randomized mix of reset, load and counting.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(15) == 0), ($urandom_range(3) == 0), W'($urandom));
        end
        // Load all-ones directly.
        step(1'b0, 1'b1, W'(MOD - 1));
        step(1'b0, 1'b0, W'(0));

        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        check("drain", step_no, 32'(exp_q.size()), 32'd0);
        done = 1'b1;
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
